// File: rtl/exec_pipe.sv
// exec_pipe: registered execute stage with valid/ready handshake, Z/V/N flag register and halt.
// Build option EXEC_PACKED_EN builds the RED and PADDSB lane datapaths; without it they report illegal.
module exec_pipe #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [2:0]        cond,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc_inc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] store_data,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_v_q, flag_v_d;
  logic              flag_n_q, flag_n_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  opcode_e           op;
  logic              accept;
  logic [DATA_W-1:0] opnd_b;
  logic [SHAMT_W-1:0] shamt, ror_lshamt;
  logic [DATA_W-1:0] sum_raw, diff_raw, add_sat, sub_sat;
  logic              add_ovf, sub_ovf;
  logic [DATA_W-1:0] red_res, paddsb_res;
  logic              packed_unsupported;
  logic              cond_true;

  logic [DATA_W-1:0] exe_result, exe_store, exe_target;
  logic              exe_taken, exe_illegal;
  logic              exe_z, exe_v, exe_n;

  assign op       = opcode_e'(opcode);
  assign in_ready = !halted_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign opnd_b   = alu_src ? imm : op_b;
  assign shamt    = imm[SHAMT_W-1:0];
  // Rotate right by s == (A >> s) | (A << (DATA_W - s)); the modulo form also covers s == 0.
  assign ror_lshamt = -shamt;

  assign sum_raw  = op_a + opnd_b;
  assign diff_raw = op_a - opnd_b;
  assign add_ovf  = (op_a[DATA_W-1] == opnd_b[DATA_W-1]) && (sum_raw[DATA_W-1] != op_a[DATA_W-1]);
  assign sub_ovf  = (op_a[DATA_W-1] != opnd_b[DATA_W-1]) && (diff_raw[DATA_W-1] != op_a[DATA_W-1]);
  assign add_sat  = add_ovf ? (op_a[DATA_W-1] ? SAT_MIN : SAT_MAX) : sum_raw;
  assign sub_sat  = sub_ovf ? (op_a[DATA_W-1] ? SAT_MIN : SAT_MAX) : diff_raw;

`ifdef EXEC_PACKED_EN
  localparam int NBYTE = DATA_W / 8;
  localparam int RED_W = 8 + $clog2(2 * NBYTE);

  logic [RED_W-1:0] red_sum;

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NBYTE; i++) begin
      red_sum = red_sum + {{(RED_W-8){op_a[8*i+7]}}, op_a[8*i +: 8]}
                        + {{(RED_W-8){opnd_b[8*i+7]}}, opnd_b[8*i +: 8]};
    end
  end

  assign red_res = {{(DATA_W-RED_W){red_sum[RED_W-1]}}, red_sum};

  genvar gi;
  for (gi = 0; gi < DATA_W / 4; gi++) begin : g_nibble
    logic [4:0] nsum;
    assign nsum = {op_a[4*gi+3], op_a[4*gi +: 4]} + {opnd_b[4*gi+3], opnd_b[4*gi +: 4]};
    // Bits 4 and 3 of the 5-bit sum differ exactly when the lane overflowed.
    assign paddsb_res[4*gi +: 4] = (nsum[4] != nsum[3]) ? (nsum[4] ? 4'h8 : 4'h7) : nsum[3:0];
  end

  assign packed_unsupported = 1'b0;
`else
  assign red_res            = '0;
  assign paddsb_res         = '0;
  assign packed_unsupported = 1'b1;
`endif

  always_comb begin
    case (cond)
      3'b000:  cond_true = !flag_z_q;
      3'b001:  cond_true = flag_z_q;
      3'b010:  cond_true = !flag_z_q && !flag_n_q;
      3'b011:  cond_true = flag_n_q;
      3'b100:  cond_true = flag_z_q || (!flag_z_q && !flag_n_q);
      3'b101:  cond_true = flag_n_q || flag_z_q;
      3'b110:  cond_true = flag_v_q;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    exe_result  = '0;
    exe_store   = '0;
    exe_target  = '0;
    exe_taken   = 1'b0;
    exe_illegal = 1'b0;
    exe_z       = flag_z_q;
    exe_v       = flag_v_q;
    exe_n       = flag_n_q;
    case (op)
      OP_ADD: begin
        exe_result = add_sat;
        exe_z = (add_sat == '0);
        exe_v = add_ovf;
        exe_n = add_sat[DATA_W-1];
      end
      OP_SUB: begin
        exe_result = sub_sat;
        exe_z = (sub_sat == '0);
        exe_v = sub_ovf;
        exe_n = sub_sat[DATA_W-1];
      end
      OP_XOR: begin
        exe_result = op_a ^ opnd_b;
        exe_z = ((op_a ^ opnd_b) == '0);
      end
      OP_SLL: begin
        exe_result = op_a << shamt;
        exe_z = (exe_result == '0);
      end
      OP_SRA: begin
        exe_result = $signed(op_a) >>> shamt;
        exe_z = (exe_result == '0);
      end
      OP_ROR: begin
        exe_result = (op_a >> shamt) | (op_a << ror_lshamt);
        exe_z = (exe_result == '0);
      end
      OP_RED: begin
        exe_result  = red_res;
        exe_illegal = packed_unsupported;
      end
      OP_PADDSB: begin
        exe_result  = paddsb_res;
        exe_illegal = packed_unsupported;
      end
      OP_LW: exe_result = op_a + imm;
      OP_SW: begin
        exe_result = op_a + imm;
        exe_store  = op_b;
      end
      OP_LLB: exe_result = {op_a[DATA_W-1:8], imm[7:0]};
      OP_LHB: begin
        exe_result        = op_a;
        exe_result[15:8]  = imm[7:0];
      end
      OP_B: begin
        exe_result = pc_inc;
        exe_taken  = cond_true;
        exe_target = pc_inc + {imm[DATA_W-2:0], 1'b0};
      end
      OP_BR: begin
        exe_result = pc_inc;
        exe_taken  = cond_true;
        exe_target = op_a;
      end
      OP_PCS:  exe_result = pc_inc;
      default: exe_result = '0;
    endcase
  end

  always_comb begin
    out_valid_d     = out_valid_q && !out_ready;
    result_d        = result_q;
    store_data_d    = store_data_q;
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;
    flag_z_d        = flag_z_q;
    flag_v_d        = flag_v_q;
    flag_n_d        = flag_n_q;
    halted_d        = halted_q;
    illegal_d       = illegal_q;
    if (accept) begin
      out_valid_d     = 1'b1;
      result_d        = exe_result;
      store_data_d    = exe_store;
      branch_taken_d  = exe_taken;
      branch_target_d = exe_target;
      flag_z_d        = exe_z;
      flag_v_d        = exe_v;
      flag_n_d        = exe_n;
      halted_d        = halted_q || (op == OP_HLT);
      illegal_d       = exe_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      result_q        <= '0;
      store_data_q    <= '0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      flag_z_q        <= 1'b0;
      flag_v_q        <= 1'b0;
      flag_n_q        <= 1'b0;
      halted_q        <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      result_q        <= result_d;
      store_data_q    <= store_data_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      flag_z_q        <= flag_z_d;
      flag_v_q        <= flag_v_d;
      flag_n_q        <= flag_n_d;
      halted_q        <= halted_d;
      illegal_q       <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign store_data    = store_data_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign flag_z        = flag_z_q;
  assign flag_v        = flag_v_q;
  assign flag_n        = flag_n_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe: scoreboard bench for exec_pipe; driver pushes model expectations, monitor pops on each output beat.
module tb_exec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  cond = '0;
  logic        alu_src = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, imm = '0, pc_inc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result, store_data, branch_target;
  logic        branch_taken, flag_z, flag_v, flag_n, halted, illegal;

  always #5 clk = ~clk;

  exec_pipe #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .cond(cond), .alu_src(alu_src), .op_a(op_a), .op_b(op_b),
    .imm(imm), .pc_inc(pc_inc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .store_data(store_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .halted(halted), .illegal(illegal)
  );

  typedef struct {
    int          op;
    logic [15:0] result;
    logic [15:0] store_data;
    bit          chk_store;
    bit          taken;
    logic [15:0] target;
    bit          chk_target;
    bit          z, v, n, halted, illegal;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mz = 0, mv = 0, mn = 0, mhalt = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic bit cond_holds(input logic [2:0] c);
    case (c)
      3'd0: return !mz;
      3'd1: return mz;
      3'd2: return !mz && !mn;
      3'd3: return mn;
      3'd4: return mz || (!mz && !mn);
      3'd5: return mn || mz;
      3'd6: return mv;
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: arithmetic on ints, architectural flags kept in mz/mv/mn.
  function automatic exp_t model(input logic [3:0] op, input logic [2:0] c, input logic asrc,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] im, input logic [15:0] pc);
    exp_t e;
    logic [15:0] bv;
    int s, u, sh, t, lane;
    e = '{default: '0};
    e.op = int'(op);
    bv = asrc ? im : b;
    sh = int'(im[3:0]);
    u  = int'(a);
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sx16(a) + sx16(bv) : sx16(a) - sx16(bv);
        mv = (s > 32767) || (s < -32768);
        s = clampi(s, -32768, 32767);
        e.result = s[15:0];
        mz = (s == 0);
        mn = (s < 0);
      end
      4'h2: begin e.result = a ^ bv; mz = (e.result == 16'h0); end
      4'h3: begin
`ifdef EXEC_PACKED_EN
        t = 0;
        for (int i = 0; i < 2; i++) begin
          t = t + int'($signed(a[8*i +: 8])) + int'($signed(bv[8*i +: 8]));
        end
        e.result = t[15:0];
`else
        e.illegal = 1;
`endif
      end
      4'h4: begin t = (u << sh) & 32'hFFFF; e.result = t[15:0]; mz = (t == 0); end
      4'h5: begin t = sx16(a) >>> sh; e.result = t[15:0]; mz = (e.result == 16'h0); end
      4'h6: begin t = ((u >> sh) | (u << (16 - sh))) & 32'hFFFF; e.result = t[15:0]; mz = (t == 0); end
      4'h7: begin
`ifdef EXEC_PACKED_EN
        for (int i = 0; i < 4; i++) begin
          lane = clampi(int'($signed(a[4*i +: 4])) + int'($signed(bv[4*i +: 4])), -8, 7);
          e.result[4*i +: 4] = lane[3:0];
        end
`else
        e.illegal = 1;
`endif
      end
      4'h8: begin t = u + int'(im); e.result = t[15:0]; end
      4'h9: begin t = u + int'(im); e.result = t[15:0]; e.store_data = b; e.chk_store = 1; end
      4'hA: e.result = {a[15:8], im[7:0]};
      4'hB: e.result = {im[7:0], a[7:0]};
      4'hC: begin
        e.result = pc; e.taken = cond_holds(c); e.chk_target = 1;
        t = int'(pc) + 2 * sx16(im); e.target = t[15:0];
      end
      4'hD: begin e.result = pc; e.taken = cond_holds(c); e.chk_target = 1; e.target = a; end
      4'hE: e.result = pc;
      default: begin e.result = 16'h0; mhalt = 1; end
    endcase
    e.z = mz; e.v = mv; e.n = mn; e.halted = mhalt;
    return e;
  endfunction

  task automatic set_ready();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] c, input logic asrc,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] im, input logic [15:0] pc);
    bit accepted = 0;
    @(negedge clk);
    opcode = op; cond = c; alu_src = asrc; op_a = a; op_b = b; imm = im; pc_inc = pc;
    in_valid = 1'b1;
    set_ready();
    for (int w = 0; w < 200 && !accepted; w++) begin
      #1;
      if (in_ready) begin
        sb.push_back(model(op, c, asrc, a, b, im, pc));
        accepted = 1;
      end else begin
        @(negedge clk);
        set_ready();
      end
    end
    check("accept_within_bound", 32'(accepted), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      set_ready();
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 6))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  // Monitor: one comparison set per transferred output beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("[TB] beat op=%0h result=%h exp=%h", e.op, result, e.result);
          check("result", 32'(result), 32'(e.result));
          check("flag_z", 32'(flag_z), 32'(e.z));
          check("flag_v", 32'(flag_v), 32'(e.v));
          check("flag_n", 32'(flag_n), 32'(e.n));
          check("branch_taken", 32'(branch_taken), 32'(e.taken));
          check("halted", 32'(halted), 32'(e.halted));
          check("illegal", 32'(illegal), 32'(e.illegal));
          if (e.chk_store)  check("store_data", 32'(store_data), 32'(e.store_data));
          if (e.chk_target) check("branch_target", 32'(branch_target), 32'(e.target));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [15:0] a, b;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_store_data", 32'(store_data), 0);
    check("rst_branch_target", 32'(branch_target), 0);
    check("rst_branch_taken", 32'(branch_taken), 0);
    check("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 1);

    // Directed vectors
    ready_mode = 0;
    send(4'h0, 3'd0, 1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    send(4'h1, 3'd0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000);
    send(4'hC, 3'd1, 1'b0, 16'h0000, 16'h0000, 16'h0004, 16'h0010);
    idle(2);

    // Output stall: result held, no second accept while out_ready is low
    ready_mode = 2;
    send(4'h0, 3'd0, 1'b0, 16'h0005, 16'h0003, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      opcode = 4'h2; op_a = 16'h00F0; op_b = 16'h000F; alu_src = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_result", 32'(result), 32'h0008);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    ready_mode = 0;
    send(4'h2, 3'd0, 1'b0, 16'h00F0, 16'h000F, 16'h0000, 16'h0000);

    send(4'h7, 3'd0, 1'b0, 16'h7777, 16'h1111, 16'h0000, 16'h0000);
    send(4'h3, 3'd0, 1'b0, 16'h7F7F, 16'h0101, 16'h0000, 16'h0000);
    send(4'h5, 3'd0, 1'b1, 16'h8000, 16'h0000, 16'h0004, 16'h0000);
    send(4'h6, 3'd0, 1'b1, 16'h000F, 16'h0000, 16'h0002, 16'h0000);
    send(4'h6, 3'd0, 1'b1, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000);
    send(4'hB, 3'd0, 1'b1, 16'h1234, 16'h0000, 16'h00AB, 16'h0000);
    send(4'hA, 3'd0, 1'b1, 16'h1234, 16'h0000, 16'hFFCD, 16'h0000);
    send(4'h8, 3'd0, 1'b1, 16'hFFFE, 16'h0000, 16'h0004, 16'h0000);
    send(4'h9, 3'd0, 1'b1, 16'h1000, 16'hBEEF, 16'hFFF0, 16'h0000);
    send(4'h1, 3'd0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000);
    send(4'hD, 3'd6, 1'b0, 16'h4321, 16'h0000, 16'h0000, 16'h0020);
    send(4'hC, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0030);
    send(4'hE, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0042);
    send(4'h2, 3'd0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 16'h0000);
    send(4'hC, 3'd4, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0100);

    // Randomized traffic with random gaps and backpressure
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      a = rnd16();
      b = ($urandom_range(0, 7) == 0) ? a : rnd16();
      send(4'($urandom_range(0, 14)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           a, b, rnd16(), 16'($urandom()));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    ready_mode = 0;
    for (int w = 0; w < 50 && sb.size() != 0; w++) idle(1);
    check("drain_random", 32'(sb.size()), 0);

    // Reset while an output is held discards it
    idle(2);
    ready_mode = 2;
    send(4'h0, 3'd0, 1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    @(negedge clk);
    #3;
    check("midstall_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midstall_rst_out_valid", 32'(out_valid), 0);
    check("midstall_rst_result", 32'(result), 0);
    sb.delete();
    mz = 0; mv = 0; mn = 0; mhalt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;

    // Halt: sticky until reset, pending output still drains
    send(4'h1, 3'd0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000);
    idle(2);
    ready_mode = 2;
    send(4'hF, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      opcode = 4'h0; op_a = 16'h0001; op_b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check("halt_halted", 32'(halted), 1);
      check("halt_in_ready", 32'(in_ready), 0);
      check("halt_out_valid", 32'(out_valid), 1);
    end
    ready_mode = 0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    check("halt_drained_out_valid", 32'(out_valid), 0);
    check("halt_drained_in_ready", 32'(in_ready), 0);
    check("halt_drained_halted", 32'(halted), 1);
    check("halt_flags_kept", {29'd0, flag_z, flag_v, flag_n}, 32'b011);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", 32'(halted), 0);
    check("halt_rst_flags", {29'd0, flag_z, flag_v, flag_n}, 0);
    check("halt_rst_out_valid", 32'(out_valid), 0);
    sb.delete();
    mz = 0; mv = 0; mn = 0; mhalt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Accepting again after reset
    send(4'h0, 3'd0, 1'b1, 16'h0002, 16'h0000, 16'h0002, 16'h0000);
    idle(3);
    check("final_scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
